// File: rtl/onewire_master_byte_pkg.sv
// Shared definitions for the 1-Wire byte master: command/state encodings,
// CRC-8 constants and default bus timings in microseconds.
package onewire_master_byte_pkg;

  typedef enum logic [1:0] {
    CMD_RESET_PRESENCE = 2'b00,
    CMD_WRITE_BYTE     = 2'b01,
    CMD_READ_BYTE      = 2'b10,
    CMD_WRITE_BIT      = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_RST_HOLD,
    ST_SLOT_LOW,
    ST_SLOT_HIGH,
    ST_RECOVER,
    ST_DONE
  } state_e;

  // Dallas CRC-8 (x^8+x^5+x^4+1) reflected; the feedback bit itself supplies bit 7.
  localparam logic [7:0] CRC8_POLY    = 8'h8C;
  localparam logic [7:0] CRC8_FB_TAPS = CRC8_POLY & 8'h7F;

  localparam int unsigned DEF_CLK_PER_US = 50;
  localparam int unsigned DEF_T_RSTL     = 480;
  localparam int unsigned DEF_T_PDS      = 70;
  localparam int unsigned DEF_T_RSTH     = 410;
  localparam int unsigned DEF_T_SLOT     = 70;
  localparam int unsigned DEF_T_W0L      = 60;
  localparam int unsigned DEF_T_W1L      = 6;
  localparam int unsigned DEF_T_RDS      = 15;
  localparam int unsigned DEF_T_REC      = 2;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return {fb, crc[7:1]} ^ ({8{fb}} & CRC8_FB_TAPS);
  endfunction

endpackage

// File: rtl/onewire_master_byte_if.sv
// Host-side command/status bundle of the 1-Wire byte master.
interface onewire_master_byte_if;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       start;
  logic       crc_clr;
  logic       busy;
  logic       done;
  logic       presence;
  logic [7:0] dout;
  logic [7:0] crc;

  modport master (output cmd, din, start, crc_clr,
                  input  busy, done, presence, dout, crc);
  modport slave  (input  cmd, din, start, crc_clr,
                  output busy, done, presence, dout, crc);
endinterface

// File: rtl/onewire_us_tick.sv
// Microsecond prescaler: one-cycle tick every DIV clocks after clr.
module onewire_us_tick #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = $clog2(DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/onewire_master_byte.sv
// 1-Wire master: reset/presence, byte write/read and single-bit write with
// running Dallas CRC-8; open-drain dq driven low or released only.
module onewire_master_byte
  import onewire_master_byte_pkg::*;
#(
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
  parameter int unsigned T_RSTL     = DEF_T_RSTL,
  parameter int unsigned T_PDS      = DEF_T_PDS,
  parameter int unsigned T_RSTH     = DEF_T_RSTH,
  parameter int unsigned T_SLOT     = DEF_T_SLOT,
  parameter int unsigned T_W0L      = DEF_T_W0L,
  parameter int unsigned T_W1L      = DEF_T_W1L,
  parameter int unsigned T_RDS      = DEF_T_RDS,
  parameter int unsigned T_REC      = DEF_T_REC
) (
  input  logic                 clk,
  input  logic                 rst,
  onewire_master_byte_if.slave bus,
  inout  wire                  dq
);

  // Last timer value of each interval; a transition fires on the tick that completes it.
  localparam logic [15:0] RSTL_LAST  = 16'(T_RSTL - 1);
  localparam logic [15:0] PDS_LAST   = 16'(T_PDS - 1);
  localparam logic [15:0] RSTH_LAST  = 16'(T_RSTH - 1);
  localparam logic [15:0] W0L_LAST   = 16'(T_W0L - 1);
  localparam logic [15:0] W1L_LAST   = 16'(T_W1L - 1);
  localparam logic [15:0] HIGH0_LAST = 16'(T_SLOT - T_W0L - 1);
  localparam logic [15:0] HIGH1_LAST = 16'(T_SLOT - T_W1L - 1);
  localparam logic [15:0] RDS_LAST   = 16'(T_RDS - T_W1L - 1);
  localparam logic [15:0] REC_LAST   = 16'(T_REC - 1);

  state_e      state, state_next;
  cmd_e        cmd_q;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [15:0] timer;
  logic        tick;
  logic        accept, pres_strobe, read_strobe, write_strobe, bit_adv;
  logic        dq_s1, dq_s2;
  logic        is_read, is_byte, cur_bit, short_low;
  logic [15:0] low_last, high_last;
  logic        presence_q;
  logic [7:0]  dout_q, crc_q;
  logic        drive_low;

  onewire_us_tick #(.DIV(CLK_PER_US)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  assign is_read   = (cmd_q == CMD_READ_BYTE);
  assign is_byte   = (cmd_q == CMD_WRITE_BYTE) || (cmd_q == CMD_READ_BYTE);
  assign cur_bit   = shreg[bit_cnt];
  assign short_low = is_read || cur_bit;
  assign low_last  = short_low ? W1L_LAST : W0L_LAST;
  assign high_last = short_low ? HIGH1_LAST : HIGH0_LAST;

  assign drive_low = (state == ST_RST_LOW) || (state == ST_SLOT_LOW);
  assign dq        = drive_low ? 1'b0 : 1'bz;

  assign bus.busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done     = (state == ST_DONE);
  assign bus.presence = presence_q;
  assign bus.dout     = dout_q;
  assign bus.crc      = crc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    pres_strobe  = 1'b0;
    read_strobe  = 1'b0;
    write_strobe = 1'b0;
    bit_adv      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (cmd_e'(bus.cmd) == CMD_RESET_PRESENCE) ? ST_RST_LOW : ST_SLOT_LOW;
        end
      end
      ST_RST_LOW:  if (tick && timer == RSTL_LAST) state_next = ST_RST_WAIT;
      ST_RST_WAIT: begin
        if (tick && timer == PDS_LAST) begin
          pres_strobe = 1'b1;
          state_next  = ST_RST_HOLD;
        end
      end
      ST_RST_HOLD: if (tick && timer == RSTH_LAST) state_next = ST_DONE;
      ST_SLOT_LOW: begin
        if (tick && timer == low_last) begin
          write_strobe = !is_read;
          state_next   = ST_SLOT_HIGH;
        end
      end
      ST_SLOT_HIGH: begin
        // Timer restarts at SLOT_HIGH entry, so slot-relative times are offset by the low phase.
        if (is_read && tick && timer == RDS_LAST) read_strobe = 1'b1;
        if (tick && timer == high_last) state_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (tick && timer == REC_LAST) begin
          if (is_byte && bit_cnt != 3'd7) begin
            bit_adv    = 1'b1;
            state_next = ST_SLOT_LOW;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= CMD_RESET_PRESENCE;
      shreg      <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      dq_s1      <= 1'b1;
      dq_s2      <= 1'b1;
      presence_q <= 1'b0;
      dout_q     <= '0;
      crc_q      <= '0;
    end else begin
      dq_s1 <= dq;
      dq_s2 <= dq_s1;

      if (state_next != state || state == ST_IDLE) timer <= '0;
      else if (tick)                               timer <= timer + 16'd1;

      if (accept) begin
        cmd_q   <= cmd_e'(bus.cmd);
        shreg   <= bus.din;
        bit_cnt <= '0;
      end else if (bit_adv) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (read_strobe) shreg[bit_cnt] <= dq_s2;
      if (pres_strobe) presence_q <= ~dq_s2;

      if (state == ST_IDLE && bus.crc_clr) crc_q <= '0;
      else if (write_strobe)               crc_q <= crc8_step(crc_q, cur_bit);
      else if (read_strobe)                crc_q <= crc8_step(crc_q, dq_s2);

      if (state_next == ST_DONE && state != ST_DONE && is_read) dout_q <= shreg;
    end
  end

endmodule

// File: tb/tb_onewire_master_byte.sv
// Directed bench for onewire_master_byte at 4 clk/us with a small 1-Wire slave model.
module tb_onewire_master_byte;

  logic clk = 1'b0;
  logic rst;
  logic slave_low;
  wire  dq;

  pullup (dq);
  assign dq = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  onewire_master_byte_if bus ();

  onewire_master_byte #(.CLK_PER_US(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dq  (dq)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned pulses[$];
  int unsigned cur_low = 0;
  int unsigned done_cnt = 0;
  int unsigned slave_mode = 0;
  logic [7:0]  slave_byte = 8'h00;
  logic [2:0]  slave_idx = 3'd0;
  logic [7:0]  exp_crc;
  int unsigned dc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] data,
                                           input int unsigned nbits);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < int'(nbits); i++) begin
      if (r[0] ^ data[i]) r = (r >> 1) ^ 8'h8C;
      else                r = r >> 1;
    end
    return r;
  endfunction

  // Bus monitor: low-pulse lengths in clocks and done pulses.
  always @(negedge clk) begin
    if (dq === 1'b0) cur_low++;
    else if (cur_low != 0) begin
      pulses.push_back(cur_low);
      cur_low = 0;
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  // Slave: mode 1 answers a reset with presence, mode 2 returns slave_byte on read slots.
  initial begin : slave_model
    slave_low = 1'b0;
    forever begin
      @(negedge clk);
      if (dq === 1'b0) begin
        if (slave_mode == 1) begin
          while (dq === 1'b0) @(negedge clk);
          repeat (120) @(negedge clk);
          slave_low = 1'b1;
          repeat (600) @(negedge clk);
          slave_low = 1'b0;
        end else if (slave_mode == 2) begin
          if (!slave_byte[slave_idx]) begin
            slave_low = 1'b1;
            repeat (120) @(negedge clk);
            slave_low = 1'b0;
          end
          slave_idx = slave_idx + 3'd1;
          while (dq === 1'b0) @(negedge clk);
        end else begin
          while (dq === 1'b0) @(negedge clk);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic clr);
    @(negedge clk);
    bus.cmd = c; bus.din = d; bus.start = 1'b1; bus.crc_clr = clr;
    @(posedge clk);
    #2;
    bus.start = 1'b0; bus.crc_clr = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int unsigned exp_cyc, input int unsigned offset);
    int unsigned cyc;
    bit seen;
    cyc = 0; seen = 1'b0;
    while (cyc < 10000) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, cyc + offset, exp_cyc);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_write_pulses(input string tag, input logic [7:0] d);
    chk({tag, "_npulses"}, pulses.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < pulses.size())
        chk($sformatf("%s_pulse%0d", tag, i), pulses[i], d[i] ? 32'd24 : 32'd240);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd = 2'b00; bus.din = 8'h00; bus.start = 1'b0; bus.crc_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dq", 32'(dq), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_presence", 32'(bus.presence), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'h00);
    chk("rst_crc", 32'(bus.crc), 32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // WRITE_BYTE 0xA5
    exp_crc = 8'h00;
    pulses.delete();
    dc = done_cnt;
    issue(2'b01, 8'hA5, 1'b0);
    wait_done("wr_a5", 2304, 0);
    repeat (3) @(negedge clk);
    chk("wr_a5_done_count", done_cnt - dc, 32'd1);
    chk_write_pulses("wr_a5", 8'hA5);
    exp_crc = crc_model(exp_crc, 8'hA5, 8);
    chk("wr_a5_crc", 32'(bus.crc), 32'(exp_crc));

    // Reset with no slave: presence 0, crc kept
    slave_mode = 0;
    pulses.delete();
    issue(2'b00, 8'h00, 1'b0);
    wait_done("rst_noslave", 3840, 0);
    repeat (3) @(negedge clk);
    chk("rst_noslave_presence", 32'(bus.presence), 32'd0);
    chk("rst_noslave_crc", 32'(bus.crc), 32'(exp_crc));
    chk("rst_noslave_low", pulses.size() > 0 ? pulses[0] : 0, 32'd1920);

    // Reset with slave answering
    slave_mode = 1;
    pulses.delete();
    dc = done_cnt;
    issue(2'b00, 8'h00, 1'b0);
    wait_done("rst_slave", 3840, 0);
    repeat (3) @(negedge clk);
    slave_mode = 0;
    chk("rst_slave_presence", 32'(bus.presence), 32'd1);
    chk("rst_slave_crc", 32'(bus.crc), 32'(exp_crc));
    chk("rst_slave_low", pulses.size() > 0 ? pulses[0] : 0, 32'd1920);
    chk("rst_slave_done_count", done_cnt - dc, 32'd1);

    // READ_BYTE, slave returns 0x3C
    slave_mode = 2; slave_byte = 8'h3C; slave_idx = 3'd0;
    pulses.delete();
    issue(2'b10, 8'h00, 1'b0);
    wait_done("rd_3c", 2304, 0);
    repeat (3) @(negedge clk);
    slave_mode = 0;
    exp_crc = crc_model(exp_crc, 8'h3C, 8);
    chk("rd_3c_dout", 32'(bus.dout), 32'h3C);
    chk("rd_3c_crc", 32'(bus.crc), 32'(exp_crc));
    chk("rd_3c_npulses", pulses.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < pulses.size()) begin
        if (slave_byte[i]) chk($sformatf("rd_3c_pulse%0d", i), pulses[i], 32'd24);
        else chk($sformatf("rd_3c_pulse%0d_range", i),
                 32'((pulses[i] >= 110) && (pulses[i] <= 130)), 32'd1);
      end

    // Start and crc_clr while busy are ignored
    pulses.delete();
    dc = done_cnt;
    issue(2'b01, 8'h5A, 1'b0);
    repeat (500) @(negedge clk);
    bus.cmd = 2'b10; bus.din = 8'hFF; bus.start = 1'b1; bus.crc_clr = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.crc_clr = 1'b0;
    wait_done("busy_ignore", 2304, 501);
    repeat (3) @(negedge clk);
    exp_crc = crc_model(exp_crc, 8'h5A, 8);
    chk("busy_ignore_crc", 32'(bus.crc), 32'(exp_crc));
    chk("busy_ignore_dout", 32'(bus.dout), 32'h3C);
    chk("busy_ignore_done_count", done_cnt - dc, 32'd1);
    chk_write_pulses("busy_ignore", 8'h5A);

    // rst inside the 4th slot of WRITE_BYTE
    issue(2'b01, 8'h00, 1'b0);
    repeat (875) @(negedge clk);
    chk("abort_dq_low_before", 32'(dq), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_dq", 32'(dq), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_presence", 32'(bus.presence), 32'd0);
    chk("abort_dout", 32'(bus.dout), 32'h00);
    chk("abort_crc", 32'(bus.crc), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    dc = done_cnt;
    repeat (50) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 32'd0);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);

    // WRITE_BIT after abort
    exp_crc = 8'h00;
    pulses.delete();
    issue(2'b11, 8'h01, 1'b0);
    wait_done("wbit", 288, 0);
    repeat (3) @(negedge clk);
    exp_crc = crc_model(exp_crc, 8'h01, 1);
    chk("wbit_crc", 32'(bus.crc), 32'(exp_crc));
    chk("wbit_npulses", pulses.size(), 32'd1);
    chk("wbit_pulse", pulses.size() > 0 ? pulses[0] : 0, 32'd24);
    chk("wbit_dout", 32'(bus.dout), 32'h00);

    // crc_clr together with start: command accumulates from 0x00
    issue(2'b11, 8'h01, 1'b1);
    wait_done("wbit_clr", 288, 0);
    repeat (3) @(negedge clk);
    chk("wbit_clr_crc", 32'(bus.crc), 32'(crc_model(8'h00, 8'h01, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
